vmem_seq: RTL and testbench
===========================

// Module: vmem_seq
// PURPOSE
//  Memory-access sequencer between the execute stage and the data memory port of the memory stage.
//  Scalar loads/stores pass straight through in one cycle.
//  Vector loads/stores are serialised into VECT_LANES single-element accesses, one per cycle.
//  The pipeline is stalled during serialisation; a vector load result is assembled and returned with a done strobe.
// PARAMETERS
//  REGI_SIZE  16  scalar word / address width; width of the memory data and address port
//  VECT_LANES 3   elements per vector
//  ELEM_SIZE  8   bits per vector element (ELEM_SIZE <= REGI_SIZE)
//  MEMO_LINES 64  memory depth; informational only, address truncation is done by the memory
// PORTS
//  clk_i       in   1                     clock, rising edge
//  rst_i       in   1                     synchronous, active-high reset
//  valid_i     in   1                     request from execute is valid
//  is_vec_i    in   1                     1 = vector access, 0 = scalar access
//  we_i        in   1                     1 = store, 0 = load
//  addr_i      in   REGI_SIZE             scalar address / vector base address
//  wd_i        in   REGI_SIZE             scalar store data
//  vwd_i       in   VECT_LANES*ELEM_SIZE  vector store data; lane i = bits [i*ELEM_SIZE +: ELEM_SIZE]
//  stall_o     out  1                     upstream must hold all request inputs stable while this is high
//  rd_o        out  REGI_SIZE             scalar load data (combinational from mem_rd_i)
//  vrd_o       out  VECT_LANES*ELEM_SIZE  assembled vector load data, registered
//  vdone_o     out  1                     one-cycle strobe: vector access complete; vrd_o valid this cycle
//  mem_we_o    out  1                     memory write enable
//  mem_a_o     out  REGI_SIZE             memory address
//  mem_wd_o    out  REGI_SIZE             memory write data
//  mem_rd_i    in   REGI_SIZE             memory read data (combinational read, same cycle)
// BEHAVIOUR
//  - Reset values: state = IDLE, idx = 0, lane buffer = 0.
//    Output reset values: stall_o = 0, vdone_o = 0, vrd_o = 0, mem_we_o = 0.
//  - mem_we_o is forced to 0 in any cycle in which rst_i = 1.
//  - FSM states: IDLE, VEC, DONE.
//  - IDLE, scalar request (valid_i & ~is_vec_i):
//      mem_a_o = addr_i, mem_wd_o = wd_i, mem_we_o = we_i, rd_o = mem_rd_i.
//      Zero added latency; stall_o = 0; remain in IDLE.
//  - IDLE, vector request (valid_i & is_vec_i):
//      stall_o = 1 combinationally; no memory access issued this cycle.
//      Latch base = addr_i, vwd = vwd_i, we = we_i; set idx = 0; next state VEC.
//  - IDLE, no request: mem_we_o = 0; remain in IDLE.
//  - VEC, per cycle:
//      mem_a_o = base + idx (modulo 2^REGI_SIZE, wraps silently).
//      mem_we_o = latched we.
//      mem_wd_o = zero-extended lane[idx].
//      On a load, lane[idx] <= mem_rd_i[ELEM_SIZE-1:0].
//      stall_o = 1.
//      If idx == VECT_LANES-1, next state DONE; otherwise idx++.
//  - DONE: stall_o = 0; vdone_o = 1; vrd_o holds the lane buffer (old data on a store); mem_we_o = 0.
//      Request inputs are ignored: the held vector request is still presented this cycle and must not be re-accepted.
//      Next state IDLE.
//  - Latency: a vector access occupies VECT_LANES + 2 cycles (accept, VECT_LANES x VEC, DONE).
//    stall_o is high for VECT_LANES + 1 cycles.
//  - vrd_o holds its value until the next vector load completes.
//  - valid_i = 0 in IDLE: no access, rd_o don't-care.
//  - Reset mid-VEC: the next state is IDLE; any remaining lanes are abandoned.
//    Writes already issued persist; vdone_o is not pulsed.
// STRUCTURE
//  - Shared package mem_pkg: typedef enum logic [1:0] {IDLE, VEC, DONE} vseq_state_t; lane-index width localparam $clog2(VECT_LANES).
//  - No sub-module: a single FSM + counter + lane register file.
//    The existing data memory connects to mem_* unchanged.
// TESTING
//  1. Scalar store addr=0x0005, wd=0xBEEF, then scalar load addr=0x0005
//     -> mem_we_o=1 on the store cycle; rd_o=0xBEEF on the load cycle; stall_o=0 throughout.
//  2. Vector store base=0x0010, vwd={0x33,0x22,0x11}
//     -> writes 0x0011@0x10, 0x0022@0x11, 0x0033@0x12 on consecutive cycles.
//     -> stall_o high for 4 cycles; vdone_o pulses once.
//  3. Vector load base=0x0010 after test 2
//     -> vrd_o={0x33,0x22,0x11} in the vdone_o cycle; no mem_we_o asserted.
//  4. Vector store base=0xFFFF
//     -> addresses 0xFFFF, 0x0000, 0x0001 (wrap-around).
//  5. rst_i asserted in the 2nd VEC cycle of a store
//     -> only lane 0 written; IDLE next cycle; stall_o=0, vdone_o never pulses, vrd_o=0.
//  6. Vector request held through DONE, then a scalar load presented the following cycle
//     -> no re-accept; the scalar load is served in IDLE with zero stall.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage sequencer: default geometry,
// FSM state encoding and the lane-index width helper.
package mem_pkg;

    localparam int DEF_REGI_SIZE  = 16;
    localparam int DEF_VECT_LANES = 3;
    localparam int DEF_ELEM_SIZE  = 8;
    // Memory depth is informational; the data memory truncates addresses itself.
    localparam int DEF_MEMO_LINES = 64;

    typedef enum logic [1:0] {
        IDLE,
        VEC,
        DONE
    } vseq_state_t;

    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    localparam int LANE_IDX_W = lane_idx_w(DEF_VECT_LANES);

endpackage

// File: rtl/vmem_seq_if.sv
// Execute-stage request / data-memory port bundle seen by the sequencer.
// slave = the sequencer, master = execute stage plus data memory.
interface vmem_seq_if
    import mem_pkg::*;
#(
    parameter int REGI_SIZE  = DEF_REGI_SIZE,
    parameter int VECT_LANES = DEF_VECT_LANES,
    parameter int ELEM_SIZE  = DEF_ELEM_SIZE
);

    logic                              valid_i;
    logic                              is_vec_i;
    logic                              we_i;
    logic [REGI_SIZE-1:0]              addr_i;
    logic [REGI_SIZE-1:0]              wd_i;
    logic [VECT_LANES*ELEM_SIZE-1:0]   vwd_i;
    logic                              stall_o;
    logic [REGI_SIZE-1:0]              rd_o;
    logic [VECT_LANES*ELEM_SIZE-1:0]   vrd_o;
    logic                              vdone_o;
    logic                              mem_we_o;
    logic [REGI_SIZE-1:0]              mem_a_o;
    logic [REGI_SIZE-1:0]              mem_wd_o;
    logic [REGI_SIZE-1:0]              mem_rd_i;

    modport slave (
        input  valid_i, is_vec_i, we_i, addr_i, wd_i, vwd_i, mem_rd_i,
        output stall_o, rd_o, vrd_o, vdone_o, mem_we_o, mem_a_o, mem_wd_o
    );

    modport master (
        output valid_i, is_vec_i, we_i, addr_i, wd_i, vwd_i, mem_rd_i,
        input  stall_o, rd_o, vrd_o, vdone_o, mem_we_o, mem_a_o, mem_wd_o
    );

endinterface

// File: rtl/vmem_seq.sv
// Memory-access sequencer: scalar accesses pass straight through, vector
// accesses are serialised into one element access per cycle while stalling.
module vmem_seq
    import mem_pkg::*;
#(
    parameter int REGI_SIZE  = DEF_REGI_SIZE,
    parameter int VECT_LANES = DEF_VECT_LANES,
    parameter int ELEM_SIZE  = DEF_ELEM_SIZE
) (
    input logic        clk_i,
    input logic        rst_i,
    vmem_seq_if.slave  bus
);

    localparam int               IDX_W    = lane_idx_w(VECT_LANES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VECT_LANES - 1);

    vseq_state_t          state_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [REGI_SIZE-1:0] base_reg;
    logic                 we_reg;
    logic                 vdone_reg;

    logic [ELEM_SIZE-1:0] vwd_lane [VECT_LANES];

    logic scalar_req;
    logic vector_req;
    logic in_vec;
    logic last_lane;
    logic vec_load;

    assign scalar_req = (state_reg == IDLE) && bus.valid_i && !bus.is_vec_i;
    assign vector_req = (state_reg == IDLE) && bus.valid_i && bus.is_vec_i;
    assign in_vec     = (state_reg == VEC);
    assign last_lane  = (idx_reg == IDX_LAST);
    assign vec_load   = in_vec && !we_reg;

    // Sequencing FSM; DONE deliberately ignores the still-held request so it
    // is not accepted a second time.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            base_reg  <= '0;
            we_reg    <= 1'b0;
            vdone_reg <= 1'b0;
        end else begin
            vdone_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (vector_req) begin
                        base_reg  <= bus.addr_i;
                        we_reg    <= bus.we_i;
                        idx_reg   <= '0;
                        state_reg <= VEC;
                    end
                end
                VEC: begin
                    if (last_lane) begin
                        state_reg <= DONE;
                        vdone_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < VECT_LANES; gi++) begin : g_lane
            logic                 lane_hit;
            logic [ELEM_SIZE-1:0] vwd_reg;
            logic [ELEM_SIZE-1:0] lane_reg;
            logic [ELEM_SIZE-1:0] vrd_reg;

            assign lane_hit = in_vec && (idx_reg == IDX_W'(gi));

            // vrd_reg is only refreshed when the last element of a load
            // arrives, so vrd_o never shows a half-assembled vector.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vwd_reg  <= '0;
                    lane_reg <= '0;
                    vrd_reg  <= '0;
                end else begin
                    if (vector_req) begin
                        vwd_reg <= bus.vwd_i[gi*ELEM_SIZE +: ELEM_SIZE];
                    end
                    if (vec_load && lane_hit) begin
                        lane_reg <= bus.mem_rd_i[ELEM_SIZE-1:0];
                    end
                    if (vec_load && last_lane) begin
                        vrd_reg <= lane_hit ? bus.mem_rd_i[ELEM_SIZE-1:0] : lane_reg;
                    end
                end
            end

            assign vwd_lane[gi]                         = vwd_reg;
            assign bus.vrd_o[gi*ELEM_SIZE +: ELEM_SIZE] = vrd_reg;
        end
    endgenerate

    assign bus.stall_o = vector_req || in_vec;
    assign bus.rd_o    = bus.mem_rd_i;
    assign bus.vdone_o = vdone_reg;

    always_comb begin
        bus.mem_a_o  = bus.addr_i;
        bus.mem_wd_o = bus.wd_i;
        bus.mem_we_o = 1'b0;
        if (in_vec) begin
            bus.mem_a_o  = base_reg + REGI_SIZE'(idx_reg);
            bus.mem_wd_o = REGI_SIZE'(vwd_lane[idx_reg]);
            bus.mem_we_o = we_reg;
        end else if (scalar_req) begin
            bus.mem_we_o = bus.we_i;
        end
        // A reset cycle must never commit a write, even mid-vector.
        if (rst_i) begin
            bus.mem_we_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_vmem_seq.sv
// Scoreboard bench for vmem_seq: expected writes and vector results are
// queued when a request is driven and compared as the sequencer produces them.
module tb_vmem_seq;
    import mem_pkg::*;

    localparam int RS = 16;
    localparam int VL = 3;
    localparam int ES = 8;

    typedef struct {
        logic [RS-1:0] addr;
        logic [RS-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vmem_seq_if #(.REGI_SIZE(RS), .VECT_LANES(VL), .ELEM_SIZE(ES)) bus ();

    vmem_seq #(.REGI_SIZE(RS), .VECT_LANES(VL), .ELEM_SIZE(ES)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Data memory with combinational read and clocked write.
    logic [RS-1:0] mem [0:65535];
    assign bus.mem_rd_i = mem[bus.mem_a_o];
    always @(posedge clk) begin
        if (bus.mem_we_o) mem[bus.mem_a_o] <= bus.mem_wd_o;
    end

    wr_t              wr_q [$];
    logic [VL*ES-1:0] vrd_q [$];
    wr_t              mon_wr;
    logic [VL*ES-1:0] mon_vrd;
    logic [VL*ES-1:0] model_vrd = '0;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we_o) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'(bus.mem_a_o), 32'hFFFF_FFFF);
            end else begin
                mon_wr = wr_q.pop_front();
                check("wr_addr", 32'(bus.mem_a_o), 32'(mon_wr.addr));
                check("wr_data", 32'(bus.mem_wd_o), 32'(mon_wr.data));
            end
        end
        if (bus.vdone_o) begin
            if (vrd_q.size() == 0) begin
                check("unexpected_vdone", 32'(bus.vrd_o), 32'hFFFF_FFFF);
            end else begin
                mon_vrd = vrd_q.pop_front();
                check("vrd", 32'(bus.vrd_o), 32'(mon_vrd));
            end
        end
    end

    task automatic idle();
        bus.valid_i  = 1'b0;
        bus.is_vec_i = 1'b0;
        bus.we_i     = 1'b0;
        bus.addr_i   = '0;
        bus.wd_i     = '0;
        bus.vwd_i    = '0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic scalar(input logic we, input logic [RS-1:0] addr,
                          input logic [RS-1:0] wd, input logic [RS-1:0] exp_rd);
        wr_t e;
        bus.valid_i  = 1'b1;
        bus.is_vec_i = 1'b0;
        bus.we_i     = we;
        bus.addr_i   = addr;
        bus.wd_i     = wd;
        if (we) begin
            e.addr = addr;
            e.data = wd;
            wr_q.push_back(e);
        end
        @(negedge clk);
        check("scalar_stall", 32'(bus.stall_o), 32'd0);
        check("scalar_we", 32'(bus.mem_we_o), 32'(we));
        if (!we) check("scalar_rd", 32'(bus.rd_o), 32'(exp_rd));
        $display("scalar %s addr=%04h wd=%04h rd=%04h", we ? "store" : "load ", addr, wd, bus.rd_o);
        @(posedge clk); #1;
        idle();
    endtask

    // Holds the vector request through the DONE cycle, as the pipeline does.
    task automatic vec(input logic we, input logic [RS-1:0] base,
                       input logic [VL*ES-1:0] vwd, input logic [VL*ES-1:0] exp_vrd);
        wr_t e;
        int  stall_cnt = 0;
        int  done_cyc  = -1;
        bus.valid_i  = 1'b1;
        bus.is_vec_i = 1'b1;
        bus.we_i     = we;
        bus.addr_i   = base;
        bus.wd_i     = '0;
        bus.vwd_i    = vwd;
        if (we) begin
            for (int i = 0; i < VL; i++) begin
                e.addr = base + RS'(i);
                e.data = RS'(vwd[i*ES +: ES]);
                wr_q.push_back(e);
            end
        end else begin
            model_vrd = exp_vrd;
        end
        vrd_q.push_back(model_vrd);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.stall_o) stall_cnt++;
            if (c == 0) check("accept_we", 32'(bus.mem_we_o), 32'd0);
            if (bus.vdone_o) begin
                done_cyc = c;
                check("done_we", 32'(bus.mem_we_o), 32'd0);
                break;
            end
            @(posedge clk); #1;
        end
        check("vec_stall_cycles", 32'(stall_cnt), 32'(VL + 1));
        check("vec_done_cycle", 32'(done_cyc), 32'(VL + 1));
        $display("vector %s base=%04h vwd=%06h vrd=%06h stall=%0d", we ? "store" : "load ",
                 base, vwd, bus.vrd_o, stall_cnt);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic reset_mid_vec();
        wr_t e;
        bus.valid_i  = 1'b1;
        bus.is_vec_i = 1'b1;
        bus.we_i     = 1'b1;
        bus.addr_i   = 16'h0020;
        bus.vwd_i    = 24'h665544;
        e.addr = 16'h0020;
        e.data = 16'h0044;
        wr_q.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_vec_we", 32'(bus.mem_we_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        model_vrd = '0;
        @(negedge clk);
        check("rst_vec_stall", 32'(bus.stall_o), 32'd0);
        check("rst_vec_vdone", 32'(bus.vdone_o), 32'd0);
        check("rst_vec_vrd", 32'(bus.vrd_o), 32'd0);
        $display("vector store base=0020 reset in 2nd VEC cycle vrd=%06h", bus.vrd_o);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.valid_i  = 1'b1;
        bus.is_vec_i = 1'b0;
        bus.we_i     = 1'b1;
        bus.addr_i   = 16'h0005;
        bus.wd_i     = 16'h1234;
        bus.vwd_i    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(bus.stall_o), 32'd0);
        check("reset_vdone", 32'(bus.vdone_o), 32'd0);
        check("reset_vrd", 32'(bus.vrd_o), 32'd0);
        check("reset_we", 32'(bus.mem_we_o), 32'd0);
        $display("reset with scalar store presented: we=%0d", bus.mem_we_o);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        @(posedge clk); #1;

        scalar(1'b1, 16'h0005, 16'hBEEF, 16'h0000);
        scalar(1'b0, 16'h0005, 16'h0000, 16'hBEEF);
        vec(1'b1, 16'h0010, 24'h332211, 24'h000000);
        vec(1'b0, 16'h0010, 24'h000000, 24'h332211);
        scalar(1'b0, 16'h0012, 16'h0000, 16'h0033);
        vec(1'b1, 16'hFFFF, 24'hCCBBAA, 24'h000000);
        vec(1'b0, 16'hFFFF, 24'h000000, 24'hCCBBAA);
        scalar(1'b0, 16'h0000, 16'h0000, 16'h00BB);
        reset_mid_vec();
        scalar(1'b0, 16'h0021, 16'h0000, 16'h0000);
        vec(1'b1, 16'h0040, 24'h778899, 24'h000000);
        scalar(1'b0, 16'h0042, 16'h0000, 16'h0077);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wr_q_left", 32'(wr_q.size()), 32'd0);
        check("vrd_q_left", 32'(vrd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem[16'h0021] = 16'h0000;
    end

endmodule
